// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone classic bus master.
package wb_master_pkg;

    localparam int WB_AW      = 26;
    localparam int WB_DW      = 32;
    localparam int WB_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } wbm_state_t;

    typedef struct packed {
        logic             err;
        logic [WB_DW-1:0] rdata;
    } wbm_rsp_t;

endpackage

// File: rtl/wbm_timeout_cnt.sv
// Saturating ack-wait counter; expired flags the last allowed bus cycle.
module wbm_timeout_cnt
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/wb_classic_master.sv
// Single-transfer Wishbone B4 classic master with registered outputs.
module wb_classic_master
    import wb_master_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = WB_TIMEOUT,
    parameter int SW      = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [SW-1:0] cmd_sel,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [SW-1:0] wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    wbm_state_t    r_state, w_state;
    logic          r_cyc, w_cyc;
    logic          r_we, w_we;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_dat, w_dat;
    logic [SW-1:0] r_sel, w_sel;
    logic          r_ready, w_ready;
    logic          r_rsp_valid, w_rsp_valid;
    wbm_rsp_t      r_rsp, w_rsp;
    logic          w_clr;
    logic          w_expired;

    wbm_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (w_clr),
        .en     (r_state == BUS),
        .expired(w_expired)
    );

    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_addr      = r_addr;
        w_dat       = r_dat;
        w_sel       = r_sel;
        w_rsp_valid = 1'b0;
        w_rsp       = r_rsp;
        w_clr       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_we    = cmd_we;
                    w_addr  = cmd_addr;
                    w_dat   = cmd_wdata;
                    w_sel   = cmd_sel;
                    w_cyc   = 1'b1;
                    w_clr   = 1'b1;
                    w_state = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a timeout landing on the same cycle
                if (wb_ack_i) begin
                    w_cyc       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp.err   = 1'b0;
                    w_rsp.rdata = r_we ? '0 : WB_DW'(wb_dat_i);
                    w_state     = GAP;
                end else if (w_expired) begin
                    w_cyc       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp.err   = 1'b1;
                    w_rsp.rdata = '0;
                    w_state     = GAP;
                end
            end
            GAP: begin
                w_cyc   = 1'b0;
                w_state = IDLE;
            end
            default: begin
                w_cyc   = 1'b0;
                w_state = IDLE;
            end
        endcase
        w_ready = (w_state == IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_addr      <= w_addr;
            r_dat       <= w_dat;
            r_sel       <= w_sel;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp       <= w_rsp;
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp.err;
    assign rsp_rdata = DW'(r_rsp.rdata);
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_addr_o = r_addr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;

endmodule

// File: tb/tb_wb_classic_master.sv
// Directed self-checking bench for wb_classic_master (TIMEOUT = 8).
module tb_wb_classic_master;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat_i = '0;
    logic          ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_classic_master #(
        .AW(AW), .DW(DW), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_rdata(rsp_rdata),
        .wb_cyc_o (cyc),
        .wb_stb_o (stb),
        .wb_we_o  (we),
        .wb_addr_o(addr),
        .wb_dat_o (dat_o),
        .wb_sel_o (sel),
        .wb_dat_i (dat_i),
        .wb_ack_i (ack)
    );

    task automatic send(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        cmd_we = w; cmd_addr = a; cmd_wdata = d; cmd_sel = s;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we = ~w; cmd_addr = '1; cmd_wdata = 32'h5555_AAAA; cmd_sel = ~s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_we = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({stb, cyc, cmd_ready, rsp_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold stb/cyc/rdy/rv got %b want 0000",
                         {stb, cyc, cmd_ready, rsp_valid});
            end
        end
        checks++;
        if ({we, addr, dat_o, sel} !== '0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h/%h/%h want 0", we, addr, dat_o, sel);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({stb, cmd_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rel0 stb/rdy got %b want 00", {stb, cmd_ready});
        end
        @(negedge clk);
        checks++;
        if ({stb, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_rel1 stb/rdy got %b want 01", {stb, cmd_ready});
        end
    endtask

    task automatic test_write();
        send(1'b1, 26'h0000010, 32'hDEADBEEF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cyc, stb, we, cmd_ready, rsp_valid} !== 5'b11100 ||
                addr !== 26'h0000010 || dat_o !== 32'hDEADBEEF || sel !== 4'hF) begin
                errors++;
                $display("FAIL write_bus%0d ctl %b a %h d %h s %h want 11100 10 deadbeef f",
                         i, {cyc, stb, we, cmd_ready, rsp_valid}, addr, dat_o, sel);
            end
            if (i == 2) begin
                dat_i = 32'h1234_5678;
                ack = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({cyc, stb, rsp_valid, rsp_err, cmd_ready} !== 5'b00100 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp ctl %b rdata %h want 00100 0",
                     {cyc, stb, rsp_valid, rsp_err, cmd_ready}, rsp_rdata);
        end
        checks++;
        if (dat_o !== 32'hDEADBEEF || we !== 1'b1) begin
            errors++;
            $display("FAIL write_hold d %h we %b want deadbeef 1", dat_o, we);
        end
        @(negedge clk);
        checks++;
        if ({stb, rsp_valid, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL write_gap stb/rv/rdy got %b want 001", {stb, rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read();
        send(1'b0, 26'h0000010, 32'h0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({stb, we} !== 2'b10 || addr !== 26'h0000010) begin
                errors++;
                $display("FAIL read_bus%0d stb/we %b a %h want 10 10", i, {stb, we}, addr);
            end
            if (i == 1) begin
                dat_i = 32'hDEADBEEF;
                ack = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        dat_i = 32'h0;
        @(negedge clk);
        checks++;
        if ({stb, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_rsp ctl %b rdata %h want 010 deadbeef",
                     {stb, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        dat_i = 32'hCAFE_F00D;
        send(1'b0, 26'h0000020, 32'h0, 4'h3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stb !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL tmo_len stb cycles %0d want %0d", n, TMO);
        end
        checks++;
        if ({cyc, rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_rsp ctl %b rdata %h want 011 0",
                     {cyc, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_gap rv/rdy got %b want 01", {rsp_valid, cmd_ready});
        end
        dat_i = 32'h0;
    endtask

    task automatic test_ack_on_timeout();
        send(1'b0, 26'h0000030, 32'h0, 4'hF);
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (i == TMO - 1) begin
                dat_i = 32'h1234_5678;
                ack = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        dat_i = 32'h0;
        @(negedge clk);
        checks++;
        if ({stb, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ack_tmo ctl %b rdata %h want 010 12345678",
                     {stb, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        ack = 1'b1;
        dat_i = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({stb, rsp_valid, cmd_ready} !== 3'b001) begin
                errors++;
                $display("FAIL stray_ack stb/rv/rdy got %b want 001",
                         {stb, rsp_valid, cmd_ready});
            end
        end
        ack = 1'b0;
        dat_i = 32'h0;
    endtask

    task automatic test_reset_mid_bus();
        send(1'b0, 26'h0000040, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL rmb_pre stb got %b want 1", stb);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rmb_rst ctl %b want 0000", {cyc, stb, rsp_valid, cmd_ready});
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({stb, rsp_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rmb_after stb/rv got %b want 00", {stb, rsp_valid});
            end
        end
        send(1'b1, 26'h0000050, 32'h0BAD_F00D, 4'h5);
        @(negedge clk);
        checks++;
        if ({stb, we} !== 2'b11 || addr !== 26'h0000050 ||
            dat_o !== 32'h0BAD_F00D || sel !== 4'h5) begin
            errors++;
            $display("FAIL rmb_wr_bus ctl %b a %h d %h s %h want 11 50 0badf00d 5",
                     {stb, we}, addr, dat_o, sel);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({stb, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmb_wr_rsp ctl %b rdata %h want 010 0",
                     {stb, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_on_timeout();
        test_stray_ack();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
